// File: rtl/brute_force_matcher_dispatch_feeder_if.sv
// Load-side bus between the brute-force matcher controller feeder and its request source / dispatch unit.
// The master modport is the feeder; the slave modport is whatever sits on the other side.
interface brute_force_matcher_dispatch_feeder_if #(
    parameter int C_BEAT_WIDTH    = 512,
    parameter int C_CELL_ID_WIDTH = 16
);
    logic                                  req_valid;
    logic                                  req_ready;
    logic [1:0]                            req_buffer_select;
    logic [15:0]                           req_kp_count;
    logic                                  src_valid;
    logic                                  src_ready;
    logic [C_BEAT_WIDTH-1:0]               src_data;
    logic [C_CELL_ID_WIDTH-1:0]            src_cell_id;
    logic                                  begin_load_fifo;
    logic [1:0]                            descriptor_buffer_select;
    logic [15:0]                           total_keypoint_load_count;
    logic                                  dispatch_unit_datain_valid;
    logic [C_BEAT_WIDTH+C_CELL_ID_WIDTH-1:0] dispatch_unit_datain;
    logic                                  dispatch_unit_done_buffer_load;
    logic                                  feeder_busy;
    logic                                  err_timeout;
    logic                                  err_early_done;

    modport master (
        input  req_valid, req_buffer_select, req_kp_count,
        input  src_valid, src_data, src_cell_id,
        input  dispatch_unit_done_buffer_load,
        output req_ready, src_ready, begin_load_fifo,
        output descriptor_buffer_select, total_keypoint_load_count,
        output dispatch_unit_datain_valid, dispatch_unit_datain,
        output feeder_busy, err_timeout, err_early_done
    );

    modport slave (
        output req_valid, req_buffer_select, req_kp_count,
        output src_valid, src_data, src_cell_id,
        output dispatch_unit_done_buffer_load,
        input  req_ready, src_ready, begin_load_fifo,
        input  descriptor_buffer_select, total_keypoint_load_count,
        input  dispatch_unit_datain_valid, dispatch_unit_datain,
        input  feeder_busy, err_timeout, err_early_done
    );
endinterface

// File: rtl/brute_force_matcher_dispatch_feeder.sv
// Feeds the dispatch unit's load port: one request -> begin pulse, gap, count*C_BEATS_PER_KP beats, done wait.
// The dispatch unit cannot stall, so all pacing and beat accounting lives here; every output is registered.
module brute_force_matcher_dispatch_feeder #(
    parameter int C_BEAT_WIDTH    = 512,
    parameter int C_CELL_ID_WIDTH = 16,
    parameter int C_BEATS_PER_KP  = 4,
    parameter int C_DONE_TIMEOUT  = 1024
) (
    input  logic clk,
    input  logic rst_n,
    brute_force_matcher_dispatch_feeder_if.master bus
);
    localparam int BEAT_W  = (C_BEATS_PER_KP > 1) ? $clog2(C_BEATS_PER_KP) : 1;
    localparam int TIMER_W = (C_DONE_TIMEOUT > 1) ? $clog2(C_DONE_TIMEOUT) : 1;
    localparam int OUT_W   = C_BEAT_WIDTH + C_CELL_ID_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BEGIN,
        S_GAP,
        S_STREAM,
        S_WAIT_DONE
    } state_t;

    state_t              state;
    logic [15:0]         kp_remaining;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [TIMER_W-1:0]  timer;

    logic beat_accept;
    logic last_beat_of_kp;
    assign beat_accept     = bus.src_valid && bus.src_ready;
    assign last_beat_of_kp = (beat_cnt == BEAT_W'(C_BEATS_PER_KP - 1));

    // Handshake flags (req_ready, src_ready, feeder_busy) are set on the transition into the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                          <= S_IDLE;
            kp_remaining                   <= '0;
            beat_cnt                       <= '0;
            timer                          <= '0;
            bus.req_ready                  <= 1'b0;
            bus.src_ready                  <= 1'b0;
            bus.begin_load_fifo            <= 1'b0;
            bus.descriptor_buffer_select   <= '0;
            bus.total_keypoint_load_count  <= '0;
            bus.dispatch_unit_datain_valid <= 1'b0;
            bus.dispatch_unit_datain       <= '0;
            bus.feeder_busy                <= 1'b0;
            bus.err_timeout                <= 1'b0;
            bus.err_early_done             <= 1'b0;
        end else begin
            bus.begin_load_fifo            <= 1'b0;
            bus.dispatch_unit_datain_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        bus.descriptor_buffer_select  <= bus.req_buffer_select;
                        bus.total_keypoint_load_count <= bus.req_kp_count;
                        kp_remaining                  <= bus.req_kp_count;
                        beat_cnt                      <= '0;
                        bus.err_timeout               <= 1'b0;
                        bus.err_early_done            <= 1'b0;
                        bus.begin_load_fifo           <= 1'b1;
                        bus.req_ready                 <= 1'b0;
                        bus.feeder_busy               <= 1'b1;
                        state                         <= S_BEGIN;
                    end else begin
                        bus.req_ready <= 1'b1;
                    end
                end

                S_BEGIN: begin
                    if (bus.dispatch_unit_done_buffer_load) bus.err_early_done <= 1'b1;
                    state <= S_GAP;
                end

                // The gap cycle lets the dispatch unit settle into its load state before any beat.
                S_GAP: begin
                    if (bus.dispatch_unit_done_buffer_load) bus.err_early_done <= 1'b1;
                    if (kp_remaining == 16'd0) begin
                        timer <= '0;
                        state <= S_WAIT_DONE;
                    end else begin
                        bus.src_ready <= 1'b1;
                        state         <= S_STREAM;
                    end
                end

                S_STREAM: begin
                    if (bus.dispatch_unit_done_buffer_load) bus.err_early_done <= 1'b1;
                    if (beat_accept) begin
                        bus.dispatch_unit_datain_valid <= 1'b1;
                        bus.dispatch_unit_datain       <= OUT_W'({bus.src_cell_id, bus.src_data});
                        if (last_beat_of_kp) begin
                            beat_cnt     <= '0;
                            kp_remaining <= kp_remaining - 16'd1;
                            if (kp_remaining == 16'd1) begin
                                bus.src_ready <= 1'b0;
                                timer         <= '0;
                                state         <= S_WAIT_DONE;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                        end
                    end
                end

                S_WAIT_DONE: begin
                    if (bus.dispatch_unit_done_buffer_load) begin
                        bus.feeder_busy <= 1'b0;
                        bus.req_ready   <= 1'b1;
                        state           <= S_IDLE;
                    end else if (timer == TIMER_W'(C_DONE_TIMEOUT - 1)) begin
                        bus.err_timeout <= 1'b1;
                        bus.feeder_busy <= 1'b0;
                        bus.req_ready   <= 1'b1;
                        state           <= S_IDLE;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end

                default: begin
                    bus.src_ready   <= 1'b0;
                    bus.feeder_busy <= 1'b0;
                    state           <= S_IDLE;
                end
            endcase
        end
    end
endmodule
